// File: rtl/ad_ip_jesd204_tpl_dac_datasel.sv
// Per-channel DAC data source selector: DMA, zero, PN7, PN15 or ramp, feeding the TPL framer.
// Pattern state advances only on beats the link consumes (ce high).
module ad_ip_jesd204_tpl_dac_datasel #(
  parameter int NUM_CHANNELS         = 4,
  parameter int CONVERTER_RESOLUTION = 16,
  parameter int SAMPLES_PER_CHANNEL  = 2,
  parameter int DAC_DATA_WIDTH       = NUM_CHANNELS*SAMPLES_PER_CHANNEL*CONVERTER_RESOLUTION
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      ce,
  input  logic [3*NUM_CHANNELS-1:0] ch_sel,
  input  logic [DAC_DATA_WIDTH-1:0] dma_data,
  input  logic                      dma_valid,
  output logic                      dma_ready,
  output logic [DAC_DATA_WIDTH-1:0] dac_data,
  output logic                      underflow,
  input  logic                      underflow_clr
);

  localparam int R    = CONVERTER_RESOLUTION;
  localparam int P    = SAMPLES_PER_CHANNEL;
  localparam int CH_W = R*P;

  localparam logic [2:0] SRC_DMA  = 3'd0;
  localparam logic [2:0] SRC_PN7  = 3'd2;
  localparam logic [2:0] SRC_PN15 = 3'd3;
  localparam logic [2:0] SRC_RAMP = 3'd4;

  logic [NUM_CHANNELS-1:0]   dma_sel;
  logic [DAC_DATA_WIDTH-1:0] dac_next;

  assign dma_ready = ce;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic [2:0]      sel;
    logic [2:0]      sel_q;
    logic            reseed;
    logic [6:0]      pn7_q;
    logic [6:0]      pn7_d;
    logic [6:0]      s7;
    logic            b7;
    logic [14:0]     pn15_q;
    logic [14:0]     pn15_d;
    logic [14:0]     s15;
    logic            b15;
    logic [15:0]     ramp_q;
    logic [15:0]     ramp_d;
    logic [15:0]     ramp_base;
    logic [15:0]     ramp_val;
    logic [CH_W-1:0] pn7_word;
    logic [CH_W-1:0] pn15_word;
    logic [CH_W-1:0] ramp_word;
    logic [CH_W-1:0] ch_word;

    assign sel        = ch_sel[3*c +: 3];
    assign reseed     = (sel != sel_q);
    assign dma_sel[c] = (sel == SRC_DMA);

    // Bit k of the beat lands in sample k/R, MSB first within each sample.
    always_comb begin
      s7       = reseed ? 7'h7F : pn7_q;
      b7       = 1'b0;
      pn7_word = '0;
      for (int k = 0; k < CH_W; k++) begin
        b7 = s7[6] ^ s7[5];
        pn7_word[(k/R)*R + (R-1-(k%R))] = b7;
        s7 = {s7[5:0], b7};
      end
      pn7_d = s7;
    end

    always_comb begin
      s15       = reseed ? 15'h7FFF : pn15_q;
      b15       = 1'b0;
      pn15_word = '0;
      for (int k = 0; k < CH_W; k++) begin
        b15 = s15[14] ^ s15[13];
        pn15_word[(k/R)*R + (R-1-(k%R))] = b15;
        s15 = {s15[13:0], b15};
      end
      pn15_d = s15;
    end

    always_comb begin
      ramp_base = reseed ? 16'h0000 : ramp_q;
      ramp_val  = '0;
      ramp_word = '0;
      for (int i = 0; i < P; i++) begin
        ramp_val = ramp_base + 16'(i);
        ramp_word[i*R +: R] = ramp_val[R-1:0];
      end
      ramp_d = ramp_base + 16'(P);
    end

    // Codes 1 and 5..7 all resolve to zero data.
    always_comb begin
      ch_word = '0;
      case (sel)
        SRC_DMA:  ch_word = dma_valid ? dma_data[c*CH_W +: CH_W] : '0;
        SRC_PN7:  ch_word = pn7_word;
        SRC_PN15: ch_word = pn15_word;
        SRC_RAMP: ch_word = ramp_word;
        default:  ch_word = '0;
      endcase
    end

    assign dac_next[c*CH_W +: CH_W] = ch_word;

    // All generators run every consumed beat; the selection change check reseeds them.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        sel_q  <= '0;
        pn7_q  <= 7'h7F;
        pn15_q <= 15'h7FFF;
        ramp_q <= '0;
      end else if (ce) begin
        sel_q  <= sel;
        pn7_q  <= pn7_d;
        pn15_q <= pn15_d;
        ramp_q <= ramp_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dac_data <= '0;
    end else if (ce) begin
      dac_data <= dac_next;
    end
  end

  // A new underflow takes priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      underflow <= 1'b0;
    end else if (ce && !dma_valid && (|dma_sel)) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_datasel.sv
// Directed bench for ad_ip_jesd204_tpl_dac_datasel with default parameters (M=4, R=16, P=2).
module tb_ad_ip_jesd204_tpl_dac_datasel;

  localparam int M  = 4;
  localparam int R  = 16;
  localparam int P  = 2;
  localparam int CW = R*P;
  localparam int DW = M*CW;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          ce = 1'b0;
  logic [3*M-1:0] ch_sel = '0;
  logic [DW-1:0] dma_data = '0;
  logic          dma_valid = 1'b0;
  logic          dma_ready;
  logic [DW-1:0] dac_data;
  logic          underflow;
  logic          underflow_clr = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  logic [6:0]  m7  [M];
  logic [14:0] m15 [M];
  logic [15:0] mramp;

  ad_ip_jesd204_tpl_dac_datasel #(
    .NUM_CHANNELS(M),
    .CONVERTER_RESOLUTION(R),
    .SAMPLES_PER_CHANNEL(P)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .ce(ce),
    .ch_sel(ch_sel),
    .dma_data(dma_data),
    .dma_valid(dma_valid),
    .dma_ready(dma_ready),
    .dac_data(dac_data),
    .underflow(underflow),
    .underflow_clr(underflow_clr)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] ramp_exp(input logic [15:0] base);
    logic [DW-1:0] w;
    logic [15:0] v;
    w = '0;
    for (int c = 0; c < M; c++)
      for (int i = 0; i < P; i++) begin
        v = base + 16'(i);
        w[(c*P+i)*R +: R] = v;
      end
    return w;
  endfunction

  task automatic pn7_beat(input int c, output logic [CW-1:0] w);
    logic [6:0] s;
    logic b;
    s = m7[c];
    w = '0;
    for (int i = 0; i < P; i++)
      for (int j = 0; j < R; j++) begin
        b = s[6] ^ s[5];
        s = {s[5:0], b};
        w[i*R + R-1-j] = b;
      end
    m7[c] = s;
  endtask

  task automatic pn15_beat(input int c, output logic [CW-1:0] w);
    logic [14:0] s;
    logic b;
    s = m15[c];
    w = '0;
    for (int i = 0; i < P; i++)
      for (int j = 0; j < R; j++) begin
        b = s[14] ^ s[13];
        s = {s[13:0], b};
        w[i*R + R-1-j] = b;
      end
    m15[c] = s;
  endtask

  task automatic test_reset;
    resetn = 1'b0; ce = 1'b0; dma_valid = 1'b0; ch_sel = '0;
    step; step;
    n_cmp++; if (dac_data !== '0) begin n_fail++; $display("[TB] FAIL reset_dac: got %h expected 0", dac_data); end
    n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_underflow: got %b expected 0", underflow); end
    n_cmp++; if (dma_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 0", dma_ready); end
    resetn = 1'b1;
  endtask

  task automatic test_ramp;
    logic [DW-1:0] e;
    ch_sel = 12'h924; dma_valid = 1'b1; ce = 1'b1; mramp = 16'h0000;
    for (int n = 1; n <= 32769; n++) begin
      step;
      e = ramp_exp(mramp);
      mramp = mramp + 16'd2;
      if (n <= 3 || (n % 4096) == 0 || n >= 32767) begin
        n_cmp++; if (dac_data !== e) begin n_fail++; $display("[TB] FAIL ramp_beat%0d: got %h expected %h", n, dac_data, e); end
      end
      if (n == 1) begin
        n_cmp++; if (dac_data[31:0] !== 32'h0001_0000) begin n_fail++; $display("[TB] FAIL ramp_first: got %h expected 00010000", dac_data[31:0]); end
      end
      if (n == 2) begin
        n_cmp++; if (dac_data[31:0] !== 32'h0003_0002) begin n_fail++; $display("[TB] FAIL ramp_second: got %h expected 00030002", dac_data[31:0]); end
      end
      if (n == 32768) begin
        n_cmp++; if (dac_data[31:0] !== 32'hFFFF_FFFE) begin n_fail++; $display("[TB] FAIL ramp_top: got %h expected fffffffe", dac_data[31:0]); end
      end
      if (n == 32769) begin
        n_cmp++; if (dac_data[31:0] !== 32'h0001_0000) begin n_fail++; $display("[TB] FAIL ramp_wrap: got %h expected 00010000", dac_data[31:0]); end
      end
    end
  endtask

  task automatic test_ce_hold;
    logic [DW-1:0] held;
    ce = 1'b1;
    n_cmp++; if (dma_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL ready_ce1: got %b expected 1", dma_ready); end
    step;
    held = ramp_exp(mramp);
    mramp = mramp + 16'd2;
    n_cmp++; if (dac_data !== held) begin n_fail++; $display("[TB] FAIL hold_pre: got %h expected %h", dac_data, held); end
    ce = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (dma_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL ready_ce0_%0d: got %b expected 0", k, dma_ready); end
      step;
      n_cmp++; if (dac_data !== held) begin n_fail++; $display("[TB] FAIL hold_%0d: got %h expected %h", k, dac_data, held); end
    end
    ce = 1'b1;
    n_cmp++; if (dma_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL ready_resume: got %b expected 1", dma_ready); end
    step;
    n_cmp++; if (dac_data[31:0] !== 32'h0005_0004) begin n_fail++; $display("[TB] FAIL hold_resume: got %h expected 00050004", dac_data[31:0]); end
  endtask

  task automatic test_pn7;
    logic [CW-1:0] w;
    resetn = 1'b0; ce = 1'b0; step; resetn = 1'b1;
    ch_sel = 12'h002; dma_valid = 1'b1; ce = 1'b1;
    dma_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    m7[0] = 7'h7F;
    for (int n = 1; n <= 1000; n++) begin
      step;
      pn7_beat(0, w);
      if (n == 1) begin
        n_cmp++; if (dac_data[15:0] !== 16'h020C) begin n_fail++; $display("[TB] FAIL pn7_first: got %h expected 020c", dac_data[15:0]); end
        n_cmp++; if (dac_data[DW-1:CW] !== 96'h0123_4567_89AB_CDEF_FEDC_BA98) begin n_fail++; $display("[TB] FAIL pn7_dma_other: got %h expected 0123456789abcdeffedcba98", dac_data[DW-1:CW]); end
      end
      n_cmp++; if (dac_data[CW-1:0] !== w) begin n_fail++; $display("[TB] FAIL pn7_beat%0d: got %h expected %h", n, dac_data[CW-1:0], w); end
    end
  endtask

  task automatic test_pn15;
    logic [CW-1:0] w;
    ch_sel = 12'h003;
    m15[0] = 15'h7FFF;
    for (int n = 1; n <= 1000; n++) begin
      step;
      pn15_beat(0, w);
      if (n == 1) begin
        n_cmp++; if (dac_data[15:0] !== 16'h0002) begin n_fail++; $display("[TB] FAIL pn15_first: got %h expected 0002", dac_data[15:0]); end
      end
      n_cmp++; if (dac_data[CW-1:0] !== w) begin n_fail++; $display("[TB] FAIL pn15_beat%0d: got %h expected %h", n, dac_data[CW-1:0], w); end
    end
  endtask

  task automatic test_switch;
    logic [CW-1:0] w;
    ch_sel = 12'h492;
    for (int c = 0; c < M; c++) m7[c] = 7'h7F;
    for (int n = 0; n < 5; n++) begin
      step;
      for (int c = 0; c < M; c++) begin
        pn7_beat(c, w);
        n_cmp++; if (dac_data[c*CW +: CW] !== w) begin n_fail++; $display("[TB] FAIL sw_pn7_b%0d_ch%0d: got %h expected %h", n, c, dac_data[c*CW +: CW], w); end
      end
    end
    ch_sel = 12'h48A;
    for (int n = 0; n < 3; n++) begin
      step;
      for (int c = 0; c < M; c++) begin
        if (c == 1) w = '0;
        else pn7_beat(c, w);
        n_cmp++; if (dac_data[c*CW +: CW] !== w) begin n_fail++; $display("[TB] FAIL sw_zero_b%0d_ch%0d: got %h expected %h", n, c, dac_data[c*CW +: CW], w); end
      end
    end
    ch_sel = 12'h492;
    m7[1] = 7'h7F;
    for (int n = 0; n < 3; n++) begin
      step;
      if (n == 0) begin
        n_cmp++; if (dac_data[CW +: R] !== 16'h020C) begin n_fail++; $display("[TB] FAIL sw_restart: got %h expected 020c", dac_data[CW +: R]); end
      end
      for (int c = 0; c < M; c++) begin
        pn7_beat(c, w);
        n_cmp++; if (dac_data[c*CW +: CW] !== w) begin n_fail++; $display("[TB] FAIL sw_back_b%0d_ch%0d: got %h expected %h", n, c, dac_data[c*CW +: CW], w); end
      end
    end
  endtask

  task automatic test_underflow;
    ch_sel = '0; ce = 1'b1; dma_valid = 1'b1; underflow_clr = 1'b1;
    dma_data = {4{32'hA5A5_0001}};
    step;
    underflow_clr = 1'b0;
    n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL uf_clear0: got %b expected 0", underflow); end
    n_cmp++; if (dac_data !== {4{32'hA5A5_0001}}) begin n_fail++; $display("[TB] FAIL uf_dma_a: got %h expected %h", dac_data, {4{32'hA5A5_0001}}); end
    dma_valid = 1'b0; dma_data = {4{32'h5A5A_0002}};
    step;
    n_cmp++; if (dac_data !== '0) begin n_fail++; $display("[TB] FAIL uf_zero_data: got %h expected 0", dac_data); end
    n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("[TB] FAIL uf_set: got %b expected 1", underflow); end
    dma_valid = 1'b1; dma_data = {4{32'h1234_5678}};
    step;
    n_cmp++; if (dac_data !== {4{32'h1234_5678}}) begin n_fail++; $display("[TB] FAIL uf_dma_c: got %h expected %h", dac_data, {4{32'h1234_5678}}); end
    n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("[TB] FAIL uf_sticky1: got %b expected 1", underflow); end
    step;
    n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("[TB] FAIL uf_sticky2: got %b expected 1", underflow); end
    underflow_clr = 1'b1;
    step;
    n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL uf_clr: got %b expected 0", underflow); end
    dma_valid = 1'b0;
    step;
    n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("[TB] FAIL uf_set_wins: got %b expected 1", underflow); end
    dma_valid = 1'b1;
    step;
    underflow_clr = 1'b0;
    n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL uf_clr2: got %b expected 0", underflow); end
    ce = 1'b0; dma_valid = 1'b0;
    step;
    n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL uf_ce0: got %b expected 0", underflow); end
    n_cmp++; if (dac_data !== {4{32'h1234_5678}}) begin n_fail++; $display("[TB] FAIL uf_ce0_hold: got %h expected %h", dac_data, {4{32'h1234_5678}}); end
    ce = 1'b1; ch_sel = 12'h249;
    step;
    n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL uf_no_dma_ch: got %b expected 0", underflow); end
    ch_sel = 12'h248;
    step;
    n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("[TB] FAIL uf_one_dma_ch: got %b expected 1", underflow); end
  endtask

  task automatic test_reset_mid;
    ch_sel = 12'h924; ce = 1'b1; dma_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step;
      n_cmp++; if (dac_data !== ramp_exp(16'(2*n))) begin n_fail++; $display("[TB] FAIL rm_pre%0d: got %h expected %h", n, dac_data, ramp_exp(16'(2*n))); end
    end
    resetn = 1'b0;
    step;
    n_cmp++; if (dac_data !== '0) begin n_fail++; $display("[TB] FAIL rm_dac: got %h expected 0", dac_data); end
    n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_underflow: got %b expected 0", underflow); end
    resetn = 1'b1;
    for (int n = 0; n < 2; n++) begin
      step;
      n_cmp++; if (dac_data !== ramp_exp(16'(2*n))) begin n_fail++; $display("[TB] FAIL rm_post%0d: got %h expected %h", n, dac_data, ramp_exp(16'(2*n))); end
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset;
    test_ramp;
    test_ce_hold;
    test_pn7;
    test_pn15;
    test_switch;
    test_underflow;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
